// File: rtl/signal_watchdog_mc_if.sv
// ============================================================================
//  Module      : signal_watchdog_mc_if
//  Description : Bundle of the multi-channel receiver watchdog signals.
//                The "master" modport belongs to whoever drives the watchdog
//                (receiver front end / bench); the "slave" modport belongs
//                to the watchdog itself.
//  Signals     :
//    enable            - DC check allowed (normally ~demod_is_ongoing)
//    sample_in         - per channel {I,Q}, channel 0 in the LSBs, I above Q
//    sample_in_strobe  - sample valid for all channels
//    ch_mask           - 1 = channel participates in the DC check
//    power_trigger     - DC check qualifier
//    signal_len        - decoded packet length
//    sig_valid         - one-cycle strobe, signal_len valid
//    min_signal_len_th - minimum legal length (zero-extended)
//    max_signal_len_th - maximum legal length
//    dc_running_sum_th - sign-imbalance threshold
//    demod_is_ongoing  - receiver busy
//    max_demod_cycles  - demodulation timeout, 0 disables
//    receiver_rst      - reset pulse to the receiver core
//    rst_cause         - {timeout,len,dc} of the last issued reset
//    rst_count         - saturating count of issued resets
//    rst_stats         - {timeout_cnt,len_cnt,dc_cnt}
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface signal_watchdog_mc_if #(
  parameter int IQ_DATA_WIDTH = 16,
  parameter int N_CH          = 2,
  parameter int TIMEOUT_WIDTH = 20
);
  logic                            enable;
  logic [N_CH*2*IQ_DATA_WIDTH-1:0] sample_in;
  logic                            sample_in_strobe;
  logic [N_CH-1:0]                 ch_mask;
  logic                            power_trigger;
  logic [15:0]                     signal_len;
  logic                            sig_valid;
  logic [3:0]                      min_signal_len_th;
  logic [15:0]                     max_signal_len_th;
  logic [7:0]                      dc_running_sum_th;
  logic                            demod_is_ongoing;
  logic [TIMEOUT_WIDTH-1:0]        max_demod_cycles;
  logic                            receiver_rst;
  logic [2:0]                      rst_cause;
  logic [15:0]                     rst_count;
  logic [47:0]                     rst_stats;

  modport master (
    output enable, sample_in, sample_in_strobe, ch_mask, power_trigger,
           signal_len, sig_valid, min_signal_len_th, max_signal_len_th,
           dc_running_sum_th, demod_is_ongoing, max_demod_cycles,
    input  receiver_rst, rst_cause, rst_count, rst_stats
  );

  modport slave (
    input  enable, sample_in, sample_in_strobe, ch_mask, power_trigger,
           signal_len, sig_valid, min_signal_len_th, max_signal_len_th,
           dc_running_sum_th, demod_is_ongoing, max_demod_cycles,
    output receiver_rst, rst_cause, rst_count, rst_stats
  );
endinterface

`default_nettype wire

// File: rtl/signal_watchdog_mc.sv
// ============================================================================
//  Module      : signal_watchdog_mc
//  Description : Multi-channel receiver watchdog. Detects DC / constant-sign
//                garbage on N_CH IQ streams while idle, illegal SIGNAL
//                lengths and over-long demodulation. Any fault produces a
//                RST_CYCLES-wide receiver_rst pulse followed by a
//                HOLDOFF_CYCLES window in which new faults are ignored.
//  Ports       :
//    clk  - system clock
//    rst  - asynchronous, active-high reset
//    bus  - signal_watchdog_mc_if.slave (all data, control and status)
//  Build option: define SIGNAL_WATCHDOG_MC_STATS_EN to get three 16-bit
//                saturating per-cause counters on bus.rst_stats; otherwise
//                rst_stats is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module signal_watchdog_mc #(
  parameter int IQ_DATA_WIDTH  = 16,
  parameter int N_CH           = 2,
  parameter int DC_WIN_LOG2    = 5,
  parameter int TIMEOUT_WIDTH  = 20,
  parameter int RST_CYCLES     = 4,
  parameter int HOLDOFF_CYCLES = 16
) (
  input logic                clk,
  input logic                rst,
  signal_watchdog_mc_if.slave bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_WIN     = 1 << DC_WIN_LOG2;     // DC window length
  localparam int c_POS_W   = DC_WIN_LOG2 + 1;      // holds 0..c_WIN
  localparam int c_CMP_W   = DC_WIN_LOG2 + 2;      // threshold compare width
  localparam int c_CH_W    = 2 * IQ_DATA_WIDTH;
  localparam int c_PH_MAX  = (RST_CYCLES > HOLDOFF_CYCLES) ? RST_CYCLES : HOLDOFF_CYCLES;
  localparam int c_PH_W    = $clog2(c_PH_MAX + 1);

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_RST  = 2'd1;
  localparam logic [1:0] c_S_HOLD = 2'd2;

  // --------------------------------------------------------------------------
  // FSM state
  // --------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [c_PH_W-1:0] r_phase;
  logic [c_PH_W-1:0] w_phase_nxt;
  logic              r_rx_rst;
  logic              w_rx_rst_nxt;
  logic              w_idle;

  assign w_idle = (r_state == c_S_IDLE);

  // --------------------------------------------------------------------------
  // DC detector
  // --------------------------------------------------------------------------
  logic                   w_dc_act;
  logic                   w_win_end;
  logic [DC_WIN_LOG2-1:0] r_win_cnt;
  logic [9:0]             w_th10;
  logic                   w_th_ok;
  logic [c_CMP_W-1:0]     w_th_c;
  logic [c_CMP_W-1:0]     w_lo_lim;
  logic [N_CH-1:0]        w_dc_ch;
  logic                   w_dc_fault;

  // The detector only runs while idle and qualified; any other time its
  // window state is discarded so a fresh window starts on re-activation.
  assign w_dc_act  = bus.enable & bus.power_trigger & w_idle;
  assign w_win_end = w_dc_act & bus.sample_in_strobe &
                     (r_win_cnt == DC_WIN_LOG2'(c_WIN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_cnt <= '0;
    end else if (!w_dc_act) begin
      r_win_cnt <= '0;
    end else if (bus.sample_in_strobe) begin
      r_win_cnt <= r_win_cnt + DC_WIN_LOG2'(1);   // wraps W-1 -> 0
    end
  end

  // Threshold of 0, or above the window length, disables the check. Once
  // enabled th <= W, so it fits in c_CMP_W bits and W-th cannot underflow.
  assign w_th10   = {2'b00, bus.dc_running_sum_th};
  assign w_th_ok  = (w_th10 != 10'd0) && (w_th10 <= 10'(c_WIN));
  assign w_th_c   = w_th10[c_CMP_W-1:0];
  assign w_lo_lim = c_CMP_W'(c_WIN) - w_th_c;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic               w_i_pos;
    logic               w_q_pos;
    logic [c_POS_W-1:0] r_pos_i;
    logic [c_POS_W-1:0] r_pos_q;
    logic [c_POS_W-1:0] w_pos_i_nxt;
    logic [c_POS_W-1:0] w_pos_q_nxt;
    logic [c_CMP_W-1:0] w_ei;
    logic [c_CMP_W-1:0] w_eq;

    // Non-negative two's complement <=> sign bit clear.
    assign w_i_pos = ~bus.sample_in[c*c_CH_W + c_CH_W - 1];
    assign w_q_pos = ~bus.sample_in[c*c_CH_W + IQ_DATA_WIDTH - 1];

    assign w_pos_i_nxt = r_pos_i + c_POS_W'(w_i_pos);
    assign w_pos_q_nxt = r_pos_q + c_POS_W'(w_q_pos);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_pos_i <= '0;
        r_pos_q <= '0;
      end else if (!w_dc_act || w_win_end) begin
        r_pos_i <= '0;
        r_pos_q <= '0;
      end else if (bus.sample_in_strobe) begin
        r_pos_i <= w_pos_i_nxt;
        r_pos_q <= w_pos_q_nxt;
      end
    end

    // Evaluation uses the sums that already include the window's last sample.
    assign w_ei = {1'b0, w_pos_i_nxt};
    assign w_eq = {1'b0, w_pos_q_nxt};

    assign w_dc_ch[c] = w_th_ok & ((w_ei >= w_th_c) | (w_ei <= w_lo_lim) |
                                   (w_eq >= w_th_c) | (w_eq <= w_lo_lim));
  end

  assign w_dc_fault = w_win_end & (|(w_dc_ch & bus.ch_mask));

  // --------------------------------------------------------------------------
  // Length check (independent of enable)
  // --------------------------------------------------------------------------
  logic w_len_fault;

  assign w_len_fault = w_idle & bus.sig_valid &
                       ((bus.signal_len < {12'd0, bus.min_signal_len_th}) |
                        (bus.signal_len > bus.max_signal_len_th));

  // --------------------------------------------------------------------------
  // Demodulation timeout
  // --------------------------------------------------------------------------
  logic [TIMEOUT_WIDTH-1:0] r_tcnt;
  logic                     w_to_fault;

  // r_tcnt counts busy clocks already seen, so comparing against limit-1
  // flags the limit-th busy clock.
  assign w_to_fault = w_idle & bus.demod_is_ongoing &
                      (bus.max_demod_cycles != '0) &
                      (r_tcnt == (bus.max_demod_cycles - TIMEOUT_WIDTH'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt <= '0;
    end else if (!bus.demod_is_ongoing || !w_idle) begin
      r_tcnt <= '0;
    end else if (r_tcnt != '1) begin
      r_tcnt <= r_tcnt + TIMEOUT_WIDTH'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Fault aggregation
  // --------------------------------------------------------------------------
  logic w_any_fault;
  logic w_enter_rst;

  assign w_any_fault = w_dc_fault | w_len_fault | w_to_fault;
  assign w_enter_rst = w_idle & w_any_fault;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_S_IDLE;
      r_phase  <= '0;
      r_rx_rst <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_phase  <= w_phase_nxt;
      r_rx_rst <= w_rx_rst_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    case (r_state)
      c_S_IDLE: begin
        if (w_any_fault) begin
          w_state_nxt = c_S_RST;
          w_phase_nxt = '0;
        end
      end
      c_S_RST: begin
        if (r_phase == c_PH_W'(RST_CYCLES - 1)) begin
          w_phase_nxt = '0;
          w_state_nxt = (HOLDOFF_CYCLES == 0) ? c_S_IDLE : c_S_HOLD;
        end else begin
          w_phase_nxt = r_phase + c_PH_W'(1);
        end
      end
      c_S_HOLD: begin
        if (r_phase == c_PH_W'(HOLDOFF_CYCLES - 1)) begin
          w_phase_nxt = '0;
          w_state_nxt = c_S_IDLE;
        end else begin
          w_phase_nxt = r_phase + c_PH_W'(1);
        end
      end
      default: begin
        w_state_nxt = c_S_IDLE;
        w_phase_nxt = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output decode (registered above so receiver_rst is glitch-free and
  // exactly tracks the cycles spent in RST)
  // --------------------------------------------------------------------------
  always_comb begin
    w_rx_rst_nxt = 1'b0;
    if (w_state_nxt == c_S_RST) begin
      w_rx_rst_nxt = 1'b1;
    end
  end

  assign bus.receiver_rst = r_rx_rst;

  // --------------------------------------------------------------------------
  // Cause and count
  // --------------------------------------------------------------------------
  logic [2:0]  r_cause;
  logic [15:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cause <= '0;
      r_count <= '0;
    end else if (w_enter_rst) begin
      r_cause <= {w_to_fault, w_len_fault, w_dc_fault};
      if (r_count != 16'hFFFF) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign bus.rst_cause = r_cause;
  assign bus.rst_count = r_count;

  // --------------------------------------------------------------------------
  // Optional per-cause statistics
  // --------------------------------------------------------------------------
`ifdef SIGNAL_WATCHDOG_MC_STATS_EN
  logic [15:0] r_st_to;
  logic [15:0] r_st_len;
  logic [15:0] r_st_dc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st_to  <= '0;
      r_st_len <= '0;
      r_st_dc  <= '0;
    end else if (w_enter_rst) begin
      if (w_to_fault  && (r_st_to  != 16'hFFFF)) r_st_to  <= r_st_to  + 16'd1;
      if (w_len_fault && (r_st_len != 16'hFFFF)) r_st_len <= r_st_len + 16'd1;
      if (w_dc_fault  && (r_st_dc  != 16'hFFFF)) r_st_dc  <= r_st_dc  + 16'd1;
    end
  end

  assign bus.rst_stats = {r_st_to, r_st_len, r_st_dc};
`else
  assign bus.rst_stats = 48'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_signal_watchdog_mc.sv
// ============================================================================
//  Module      : tb_signal_watchdog_mc
//  Description : Self-checking bench for signal_watchdog_mc. Directed
//                sequences with fixed expectations, a length-check vector
//                table, and a randomized phase compared cycle by cycle with
//                a counting model of the watchdog rules.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_signal_watchdog_mc;

  localparam int IQW = 16;
  localparam int NCH = 2;
  localparam int WL2 = 5;
  localparam int TW  = 20;
  localparam int RC  = 4;
  localparam int HC  = 16;
  localparam int WIN = 1 << WL2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  signal_watchdog_mc_if #(.IQ_DATA_WIDTH(IQW), .N_CH(NCH), .TIMEOUT_WIDTH(TW)) bus ();

  signal_watchdog_mc #(
    .IQ_DATA_WIDTH (IQW),
    .N_CH          (NCH),
    .DC_WIN_LOG2   (WL2),
    .TIMEOUT_WIDTH (TW),
    .RST_CYCLES    (RC),
    .HOLDOFF_CYCLES(HC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  int          m_blk;             // remaining blocked clocks (RST+HOLD)
  int          m_n;               // samples in current DC window
  int          m_pi[NCH];
  int          m_pq[NCH];
  int          m_run;             // consecutive busy idle clocks
  logic [2:0]  m_cause;
  int          m_count;

  task automatic model_clear_win();
    m_n = 0;
    for (int c = 0; c < NCH; c++) begin m_pi[c] = 0; m_pq[c] = 0; end
  endtask

  task automatic model_reset();
    m_blk = 0; m_run = 0; m_cause = 3'b000; m_count = 0;
    model_clear_win();
  endtask

  task automatic model_step();
    bit fdc, flen, fto;
    int th, md;
    logic signed [IQW-1:0] iv, qv;
    fdc = 0; flen = 0; fto = 0;
    if (m_blk == 0) begin
      if (!(bus.enable && bus.power_trigger)) model_clear_win();
      else if (bus.sample_in_strobe) begin
        for (int c = 0; c < NCH; c++) begin
          iv = bus.sample_in[c*2*IQW + IQW +: IQW];
          qv = bus.sample_in[c*2*IQW +: IQW];
          if (iv >= 0) m_pi[c]++;
          if (qv >= 0) m_pq[c]++;
        end
        m_n++;
        if (m_n == WIN) begin
          th = int'(bus.dc_running_sum_th);
          for (int c = 0; c < NCH; c++)
            if (bus.ch_mask[c] && th != 0 && th <= WIN &&
                (m_pi[c] >= th || m_pi[c] <= WIN - th ||
                 m_pq[c] >= th || m_pq[c] <= WIN - th)) fdc = 1;
          model_clear_win();
        end
      end
      flen = bus.sig_valid &&
             (int'(bus.signal_len) < int'(bus.min_signal_len_th) ||
              int'(bus.signal_len) > int'(bus.max_signal_len_th));
      md = int'(bus.max_demod_cycles);
      if (bus.demod_is_ongoing) begin
        fto = (md != 0) && (m_run == md - 1);
        m_run++;
      end else m_run = 0;
      if (fdc || flen || fto) begin
        m_cause = {fto, flen, fdc};
        if (m_count < 65535) m_count++;
        m_blk = RC + HC;
      end
    end else begin
      model_clear_win();
      m_run = 0;
      m_blk--;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_rx_rst", 64'(bus.receiver_rst), 64'(m_blk > HC));
    chk("model_cause", 64'(bus.rst_cause), 64'(m_cause));
    chk("model_count", 64'(bus.rst_count), 64'(m_count));
  endtask

  task automatic set_iq(input int c, input int iv, input int qv);
    bus.sample_in[c*2*IQW + IQW +: IQW] = IQW'(iv);
    bus.sample_in[c*2*IQW +: IQW]       = IQW'(qv);
  endtask

  task automatic idle_inputs();
    bus.enable = 0; bus.power_trigger = 0; bus.sample_in = '0;
    bus.sample_in_strobe = 0; bus.ch_mask = '0; bus.signal_len = 16'd100;
    bus.sig_valid = 0; bus.min_signal_len_th = 4'd0; bus.max_signal_len_th = 16'hFFFF;
    bus.dc_running_sum_th = 8'd0; bus.demod_is_ongoing = 0; bus.max_demod_cycles = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic stats_expect(input string nm, input logic [47:0] when_en);
`ifdef SIGNAL_WATCHDOG_MC_STATS_EN
    chk(nm, 64'(bus.rst_stats), 64'(when_en));
`else
    chk(nm, 64'(bus.rst_stats), 64'd0);
`endif
  endtask

  typedef struct {
    logic [15:0] len;
    logic [3:0]  mn;
    logic [15:0] mx;
    bit          bad;
  } lv_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    lv_t lv[8];
    int  exp_cnt;
    int  base;
    bit  fired;
    int  bias_i[NCH], bias_q[NCH];
    int  bl[5];
    int  thl[9];
    int  mag;

    lv[0] = '{16'd3,     4'd14, 16'd4095,  1'b1};
    lv[1] = '{16'd4096,  4'd14, 16'd4095,  1'b1};
    lv[2] = '{16'd100,   4'd14, 16'd4095,  1'b0};
    lv[3] = '{16'd14,    4'd14, 16'd4095,  1'b0};
    lv[4] = '{16'd13,    4'd14, 16'd4095,  1'b1};
    lv[5] = '{16'd4095,  4'd14, 16'd4095,  1'b0};
    lv[6] = '{16'd0,     4'd0,  16'd0,     1'b0};
    lv[7] = '{16'd65535, 4'd15, 16'd65534, 1'b1};
    bl  = '{0, 10, 50, 90, 100};
    thl = '{0, 16, 20, 24, 28, 30, 32, 33, 40};

    idle_inputs();
    do_reset();
    chk("reset_rx_rst", 64'(bus.receiver_rst), 64'd0);
    chk("reset_cause",  64'(bus.rst_cause), 64'd0);
    chk("reset_count",  64'(bus.rst_count), 64'd0);
    chk("reset_stats",  64'(bus.rst_stats), 64'd0);
    exp_cnt = 0;

    // ---- DC on channel 0 ----
    bus.dc_running_sum_th = 8'd28; bus.ch_mask = 2'b01;
    bus.enable = 1; bus.power_trigger = 1;
    for (int k = 0; k < WIN; k++) begin
      set_iq(0, 100, (k % 2 == 1) ? 100 : -100);
      set_iq(1, (k % 2 == 1) ? 5 : -5, (k % 2 == 1) ? -7 : 7);
      bus.sample_in_strobe = 1;
      tick();
      if (k == WIN - 2) chk("dc_no_early", 64'(bus.receiver_rst), 64'd0);
    end
    bus.sample_in_strobe = 0;
    exp_cnt++;
    chk("dc0_rise", 64'(bus.receiver_rst), 64'd1);
    for (int k = 1; k < RC; k++) begin
      tick();
      chk("dc0_pulse_hi", 64'(bus.receiver_rst), 64'd1);
    end
    tick();
    chk("dc0_pulse_end", 64'(bus.receiver_rst), 64'd0);
    chk("dc0_cause", 64'(bus.rst_cause), 64'd1);
    chk("dc0_count", 64'(bus.rst_count), 64'(exp_cnt));
    repeat (HC + 2) tick();

    // ---- DC on channel 1, masked then unmasked ----
    for (int pass = 0; pass < 2; pass++) begin
      bus.ch_mask = (pass == 0) ? 2'b01 : 2'b11;
      for (int k = 0; k < WIN; k++) begin
        set_iq(0, (k % 2 == 1) ? 9 : -9, (k % 2 == 1) ? -9 : 9);
        set_iq(1, 100, (k % 2 == 1) ? 100 : -100);
        bus.sample_in_strobe = 1;
        tick();
      end
      bus.sample_in_strobe = 0;
      if (pass == 0) chk("dc1_masked", 64'(bus.receiver_rst), 64'd0);
    end
    exp_cnt++;
    chk("dc1_unmasked", 64'(bus.receiver_rst), 64'd1);
    chk("dc1_cause", 64'(bus.rst_cause), 64'd1);
    chk("dc1_count", 64'(bus.rst_count), 64'(exp_cnt));
    repeat (RC + HC + 2) tick();
    bus.enable = 0; bus.power_trigger = 0;

    // ---- length-check table ----
    for (int i = 0; i < 8; i++) begin
      bus.signal_len = lv[i].len; bus.min_signal_len_th = lv[i].mn;
      bus.max_signal_len_th = lv[i].mx; bus.sig_valid = 1;
      tick();
      bus.sig_valid = 0;
      chk("len_rx_rst", 64'(bus.receiver_rst), 64'(lv[i].bad));
      if (lv[i].bad) begin
        exp_cnt++;
        chk("len_cause", 64'(bus.rst_cause), 64'd2);
      end
      chk("len_count", 64'(bus.rst_count), 64'(exp_cnt));
      repeat (RC + HC + 1) tick();
    end
    bus.min_signal_len_th = 4'd14; bus.max_signal_len_th = 16'd4095;

    // ---- demod timeout ----
    bus.max_demod_cycles = TW'(1000); bus.demod_is_ongoing = 1;
    repeat (999) tick();
    chk("to_not_yet", 64'(bus.receiver_rst), 64'd0);
    tick();
    bus.demod_is_ongoing = 0;
    exp_cnt++;
    chk("to_rise", 64'(bus.receiver_rst), 64'd1);
    chk("to_cause", 64'(bus.rst_cause), 64'd4);
    repeat (RC + HC + 1) tick();
    bus.max_demod_cycles = '0; bus.demod_is_ongoing = 1;
    fired = 0;
    repeat (1100) begin
      tick();
      if (bus.receiver_rst) fired = 1;
    end
    bus.demod_is_ongoing = 0;
    chk("to_disabled", 64'(fired), 64'd0);

    // ---- faults during RST / HOLDOFF are ignored ----
    base = exp_cnt;
    bus.signal_len = 16'd3; bus.sig_valid = 1;
    tick();                       // fault registered, pulse starts
    tick();                       // second fault while in RST
    bus.sig_valid = 0;
    repeat (6) tick();            // now in HOLDOFF
    bus.sig_valid = 1;
    tick();
    bus.sig_valid = 0;
    chk("holdoff_ignore", 64'(bus.receiver_rst), 64'd0);
    repeat (RC + HC) tick();
    chk("busy_once_count", 64'(bus.rst_count), 64'(base + 1));
    chk("busy_once_rx", 64'(bus.receiver_rst), 64'd0);

    // ---- simultaneous timeout + length, statistics ----
    do_reset();
    bus.max_demod_cycles = TW'(5); bus.demod_is_ongoing = 1;
    repeat (4) tick();
    bus.signal_len = 16'd3; bus.sig_valid = 1;
    tick();
    bus.sig_valid = 0; bus.demod_is_ongoing = 0;
    chk("both_rise", 64'(bus.receiver_rst), 64'd1);
    chk("both_cause", 64'(bus.rst_cause), 64'd6);
    chk("both_count", 64'(bus.rst_count), 64'd1);
    stats_expect("both_stats", {16'd1, 16'd1, 16'd0});
    repeat (RC + HC + 1) tick();

    // ---- asynchronous reset in the 2nd RST cycle ----
    bus.sig_valid = 1;
    tick();
    bus.sig_valid = 0;
    tick();
    chk("midrst_pre", 64'(bus.receiver_rst), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_rx", 64'(bus.receiver_rst), 64'd0);
    chk("midrst_cause", 64'(bus.rst_cause), 64'd0);
    chk("midrst_count", 64'(bus.rst_count), 64'd0);
    chk("midrst_stats", 64'(bus.rst_stats), 64'd0);
    idle_inputs();
    do_reset();

    // ---- randomized phase against the model ----
    for (int c = 0; c < NCH; c++) begin bias_i[c] = 50; bias_q[c] = 50; end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 64 == 0)
        for (int c = 0; c < NCH; c++) begin
          bias_i[c] = bl[$urandom_range(0, 4)];
          bias_q[c] = bl[$urandom_range(0, 4)];
        end
      if (cyc % 150 == 0) begin
        bus.dc_running_sum_th = 8'(thl[$urandom_range(0, 8)]);
        bus.ch_mask           = NCH'($urandom);
        bus.max_demod_cycles  = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(8, 80));
        bus.min_signal_len_th = 4'($urandom_range(0, 15));
        bus.max_signal_len_th = 16'($urandom_range(50, 250));
      end
      bus.enable           = ($urandom_range(0, 19) != 0);
      bus.power_trigger    = ($urandom_range(0, 19) != 0);
      bus.sample_in_strobe = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NCH; c++) begin
        mag = int'($urandom_range(0, 3000));
        set_iq(c, (int'($urandom_range(0, 99)) < bias_i[c]) ? mag : -mag - 1,
                  (int'($urandom_range(0, 99)) < bias_q[c]) ? mag : -mag - 1);
      end
      bus.sig_valid  = ($urandom_range(0, 49) == 0);
      bus.signal_len = 16'($urandom_range(0, 300));
      if ($urandom_range(0, 29) == 0) bus.demod_is_ongoing = ~bus.demod_is_ongoing;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/signal_watchdog_mc.md
Name: signal_watchdog_mc

Overview:
- Parametrised, multi-channel successor to the receiver watchdog in front of dot11.
- Monitors N_CH IQ streams for DC/constant-sign garbage while the receiver is idle.
- Checks the decoded SIGNAL length against a window, and bounds demodulation duration with a cycle timeout.
- On any fault, issues a timed receiver_rst pulse followed by a hold-off, and reports the cause.

Parameters:
- IQ_DATA_WIDTH, 16, bits per I or Q component.
- N_CH, 2, number of antenna channels (1..4).
- DC_WIN_LOG2, 5, log2 of the DC evaluation window in samples (3..7).
- TIMEOUT_WIDTH, 20, width of the demod timeout counter.
- RST_CYCLES, 4, receiver_rst pulse width in clocks (>=1).
- HOLDOFF_CYCLES, 16, clocks after the pulse during which triggers are ignored (>=0).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  DC check allowed (driven by ~demod_is_ongoing)
- sample_in  in  N_CH*2*IQ_DATA_WIDTH  per channel {I,Q}, channel 0 in LSBs, I above Q
- sample_in_strobe  in  1  sample valid for all channels
- ch_mask  in  N_CH  1 = channel participates in DC check
- power_trigger  in  1  DC check qualifier
- signal_len  in  16  decoded packet length
- sig_valid  in  1  one-cycle strobe, signal_len valid
- min_signal_len_th  in  4  minimum legal length (zero-extended)
- max_signal_len_th  in  16  maximum legal length
- dc_running_sum_th  in  8  imbalance threshold
- demod_is_ongoing  in  1  receiver busy
- max_demod_cycles  in  TIMEOUT_WIDTH  timeout limit; 0 disables
- receiver_rst  out  1  reset pulse to the receiver core
- rst_cause  out  3  {timeout,len,dc}, latched cause of the last reset
- rst_count  out  16  saturating count of issued resets
- rst_stats  out  48  {timeout_cnt,len_cnt,dc_cnt}, see Optional Feature

Behaviour:
- Reset values: receiver_rst=0, rst_cause=0, rst_count=0, rst_stats=0, FSM=IDLE, all counters 0.
- Let W=2^DC_WIN_LOG2.

DC detector (per channel c):
- Active only when enable & power_trigger & FSM==IDLE. When inactive, the window counters clear.
- On each sample_in_strobe:
  - posI[c] += (I>=0), posQ[c] += (Q>=0); win_cnt++ (shared by all channels).
  - When win_cnt wraps W-1 -> 0, evaluate using the sums including the current sample, then clear.
  - dc[c] = posI>=th | posI<=W-th | posQ>=th | posQ<=W-th, where th=dc_running_sum_th and the comparison width is DC_WIN_LOG2+2.
  - th=0 or th>W disables the check.
- dc_fault = OR over c of (dc[c] & ch_mask[c]). It is evaluated only in the window-end cycle.

Length check:
- On sig_valid in IDLE: len_fault = signal_len < min_signal_len_th | signal_len > max_signal_len_th.
- Independent of enable.

Timeout:
- tcnt increments each clock while demod_is_ongoing & FSM==IDLE; it clears when demod_is_ongoing=0.
- timeout_fault when max_demod_cycles!=0 and tcnt==max_demod_cycles-1 (fires after exactly max_demod_cycles busy clocks).
- tcnt saturates; it never wraps.

FSM:
- IDLE:
  - Any fault -> RST.
  - rst_cause <= {timeout_fault,len_fault,dc_fault}; simultaneous faults are OR'd in the same cycle.
  - rst_count saturating +1 (holds at 16'hFFFF).
- RST:
  - receiver_rst=1 for exactly RST_CYCLES clocks, asserted the clock after the fault cycle (1-cycle latency).
  - All detectors are cleared and ignore inputs.
  - Then go to HOLDOFF, or to IDLE if HOLDOFF_CYCLES==0.
- HOLDOFF: faults ignored, detectors held clear, for HOLDOFF_CYCLES clocks, then IDLE.
- rst_cause holds until the next reset event. It is never cleared except by reset.
- Asynchronous reset mid-pulse: receiver_rst deasserts immediately and all state returns to reset values.
- receiver_rst is a registered output, glitch-free.

Optional Feature:
- Macro SIGNAL_WATCHDOG_MC_STATS_EN.
- When defined: three 16-bit saturating per-cause counters, each incremented on entry to RST when its cause bit is set. They are concatenated on rst_stats.
- When undefined: no counters are synthesised and rst_stats is tied to 0.
- rst_count and all other behaviour are identical in both builds.

Test Plan:
- Config N_CH=2, W=32, th=28, ch_mask=2'b01. Channel 0 fed I=+100 constant for 32 strobes, enable=power_trigger=1 -> receiver_rst high the cycle after the 32nd strobe, for 4 clocks; rst_cause=3'b001; rst_count=1.
- Same constant stimulus on channel 1 only, with ch_mask=2'b01 -> no receiver_rst. Then ch_mask=2'b11 -> reset issued at the next window end.
- sig_valid with signal_len=3, min=14 -> rst_cause=3'b010. Then signal_len=4096, max=4095 -> rst_cause=3'b010 and rst_count=2. Then signal_len=100 -> no reset.
- max_demod_cycles=1000, demod_is_ongoing held high -> receiver_rst rises at clock 1001; max_demod_cycles=0 -> never fires.
- A second fault injected during RST and HOLDOFF -> ignored, rst_count increments once. Asserting reset in the 2nd RST cycle -> receiver_rst=0 immediately and all outputs return to 0.
- SIGNAL_WATCHDOG_MC_STATS_EN defined, with sig_valid bad-length in the same cycle as a timeout -> rst_cause=3'b110 and rst_stats={16'd1,16'd1,16'd0}. Macro undefined -> rst_stats=0.
